// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path definitions for the RV32I pipeline: state encoding,
// default widths and the redirect controller's decoded output bundle.
package riscv_ctrl_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned PERF_W_DEF = 32;
  localparam int unsigned REG_IDX_W  = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } ctrl_state_e;

  // Single-bit pipeline controls produced together by the sequencer
  typedef struct packed {
    logic pc_we;
    logic pc_src;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic busy;
  } ctrl_out_t;

endpackage

// File: rtl/pipeline_redirect_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the redirect
// sequencer (slave): EX/ID hazard inputs, fetch handshake, control outputs.
interface pipeline_redirect_ctrl_if
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) ();

  logic                 ex_pcsel;
  logic [XLEN-1:0]      ex_target;
  logic                 ex_memread;
  logic [REG_IDX_W-1:0] ex_rd;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 imem_ready;

  logic                 pc_we;
  logic                 pc_src;
  logic [XLEN-1:0]      redirect_pc;
  logic                 if_id_stall;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 busy;
  logic [PERF_W-1:0]    redirect_cnt;
  logic [PERF_W-1:0]    lu_stall_cnt;
  logic [PERF_W-1:0]    fetch_stall_cnt;

  modport master (
    output ex_pcsel, ex_target, ex_memread, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, imem_ready,
    input  pc_we, pc_src, redirect_pc, if_id_stall, if_id_flush,
           id_ex_flush, busy, redirect_cnt, lu_stall_cnt, fetch_stall_cnt
  );

  modport slave (
    input  ex_pcsel, ex_target, ex_memread, ex_rd,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, imem_ready,
    output pc_we, pc_src, redirect_pc, if_id_stall, if_id_flush,
           id_ex_flush, busy, redirect_cnt, lu_stall_cnt, fetch_stall_cnt
  );

endinterface

// File: rtl/pipeline_redirect_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in EX writes a register the ID
// instruction reads. x0 never creates a dependency.
module load_use_detect
  import riscv_ctrl_pkg::*;
(
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  output logic                 lu_c
);

  // Pure compare, no state
  always_comb begin
    lu_c = ex_memread && (ex_rd != REG_IDX_W'(0)) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_redirect_ctrl.sv
// Redirect / stall sequencer for the 5-stage core. RUN outputs are
// combinational from inputs and state; a redirect seen while the fetch is
// stalled is parked in target_q and replayed from HOLD once imem_ready rises.
// Optional event counters: define REDIRECT_PERF_EN.
module pipeline_redirect_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input logic                     clk,
  input logic                     rst,
  pipeline_redirect_ctrl_if.slave bus
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] target_q;
  logic            target_ld;
  logic            lu;
  logic            lu_rule;
  ctrl_out_t       ctl;
  logic [XLEN-1:0] redirect_pc_c;

  load_use_detect u_lu (
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .lu_c       (lu)
  );

  // State register; reset drops any pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Parked redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            target_q <= XLEN'(0);
    else if (target_ld) target_q <= bus.ex_target;
  end

  // Next state and pipeline controls; redirect outranks load-use
  always_comb begin
    state_d       = state_q;
    target_ld     = 1'b0;
    lu_rule       = 1'b0;
    ctl           = '0;
    redirect_pc_c = bus.ex_target;

    case (state_q)
      ST_RUN: begin
        if (bus.ex_pcsel && bus.imem_ready) begin
          ctl.pc_we       = 1'b1;
          ctl.pc_src      = 1'b1;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end else if (bus.ex_pcsel) begin
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
          target_ld       = 1'b1;
          state_d         = ST_HOLD;
        end else if (lu) begin
          ctl.if_id_stall = 1'b1;
          ctl.id_ex_flush = 1'b1;
          lu_rule         = 1'b1;
        end else if (!bus.imem_ready) begin
          ctl.if_id_flush = 1'b1;
        end else begin
          ctl.pc_we = 1'b1;
        end
      end
      ST_HOLD: begin
        ctl.busy        = 1'b1;
        ctl.if_id_flush = 1'b1;
        ctl.id_ex_flush = 1'b1;
        redirect_pc_c   = target_q;
        if (bus.imem_ready) begin
          ctl.pc_we  = 1'b1;
          ctl.pc_src = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // While reset is held the pipeline is fully bubbled and the PC frozen
    if (rst) begin
      ctl             = '0;
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      redirect_pc_c   = XLEN'(0);
      lu_rule         = 1'b0;
    end
  end

  assign bus.pc_we       = ctl.pc_we;
  assign bus.pc_src      = ctl.pc_src;
  assign bus.redirect_pc = redirect_pc_c;
  assign bus.if_id_stall = ctl.if_id_stall;
  assign bus.if_id_flush = ctl.if_id_flush;
  assign bus.id_ex_flush = ctl.id_ex_flush;
  assign bus.busy        = ctl.busy;

`ifdef REDIRECT_PERF_EN
  logic [PERF_W-1:0] redirect_cnt_q;
  logic [PERF_W-1:0] lu_stall_cnt_q;
  logic [PERF_W-1:0] fetch_stall_cnt_q;

  // Free-running event counters, wrapping at 2^PERF_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q    <= PERF_W'(0);
      lu_stall_cnt_q    <= PERF_W'(0);
      fetch_stall_cnt_q <= PERF_W'(0);
    end else begin
      if (ctl.pc_we && ctl.pc_src) redirect_cnt_q    <= redirect_cnt_q + PERF_W'(1);
      if (lu_rule)                 lu_stall_cnt_q    <= lu_stall_cnt_q + PERF_W'(1);
      if (!bus.imem_ready)         fetch_stall_cnt_q <= fetch_stall_cnt_q + PERF_W'(1);
    end
  end

  assign bus.redirect_cnt    = redirect_cnt_q;
  assign bus.lu_stall_cnt    = lu_stall_cnt_q;
  assign bus.fetch_stall_cnt = fetch_stall_cnt_q;
`else
  // Counters compiled out; ports stay for a stable interface
  logic perf_unused;
  assign perf_unused         = lu_rule;
  assign bus.redirect_cnt    = PERF_W'(0);
  assign bus.lu_stall_cnt    = PERF_W'(0);
  assign bus.fetch_stall_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Randomized + directed bench for pipeline_redirect_ctrl with a queue-based
// scoreboard. Stimulus pushes the reference model's expected outputs; a
// negedge monitor pops and compares.
module tb_pipeline_redirect_ctrl;

  localparam int unsigned XL = 32;
  localparam int unsigned PW = 4;
`ifdef REDIRECT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic          rst;
    logic          pcsel;
    logic [XL-1:0] target;
    logic          memread;
    logic [4:0]    ex_rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          use1;
    logic          use2;
    logic          imem;
  } stim_t;

  typedef struct packed {
    logic          pc_we;
    logic          pc_src;
    logic [XL-1:0] rpc;
    logic          stall;
    logic          iflush;
    logic          eflush;
    logic          busy;
    logic [PW-1:0] rc;
    logic [PW-1:0] lc;
    logic [PW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_redirect_ctrl_if #(.XLEN(XL), .PERF_W(PW)) bus ();

  pipeline_redirect_ctrl #(.XLEN(XL), .PERF_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: a pending redirect is just "a target waiting for a fetch"
  logic [XL-1:0] pend_q[$];
  logic [PW-1:0] m_rc = '0, m_lc = '0, m_fc = '0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.pcsel = 1'b0; s.target = '0; s.memread = 1'b0;
    s.ex_rd = '0; s.rs1 = '0; s.rs2 = '0; s.use1 = 1'b0; s.use2 = 1'b0;
    s.imem = 1'b1;
    return s;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit   dep;
    bit   took_lu;
    e       = '0;
    took_lu = 1'b0;
    if (s.rst) begin
      pend_q.delete();
      m_rc = '0; m_lc = '0; m_fc = '0;
      e.iflush = 1'b1;
      e.eflush = 1'b1;
      return e;
    end
    if (PERF) begin e.rc = m_rc; e.lc = m_lc; e.fc = m_fc; end
    dep = s.memread && (s.ex_rd != 0) &&
          ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    if (pend_q.size() != 0) begin
      // Waiting to replay: EX content is junk, only the fetch matters
      e.busy = 1; e.iflush = 1; e.eflush = 1; e.rpc = pend_q[0];
      if (s.imem) begin
        e.pc_we = 1; e.pc_src = 1;
        void'(pend_q.pop_front());
      end
    end else begin
      e.rpc = s.target;
      if (s.pcsel) begin
        e.iflush = 1; e.eflush = 1;
        if (s.imem) begin e.pc_we = 1; e.pc_src = 1; end
        else pend_q.push_back(s.target);
      end else if (dep) begin
        e.stall = 1; e.eflush = 1; took_lu = 1'b1;
      end else if (!s.imem) begin
        e.iflush = 1;
      end else begin
        e.pc_we = 1;
      end
    end
    if (e.pc_we && e.pc_src) m_rc = m_rc + 1'b1;
    if (took_lu)             m_lc = m_lc + 1'b1;
    if (!s.imem)             m_fc = m_fc + 1'b1;
    return e;
  endfunction

  // Drive one cycle of stimulus shortly after the rising edge
  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst            = s.rst;
    bus.ex_pcsel   = s.pcsel;
    bus.ex_target  = s.target;
    bus.ex_memread = s.memread;
    bus.ex_rd      = s.ex_rd;
    bus.id_rs1     = s.rs1;
    bus.id_rs2     = s.rs2;
    bus.id_use_rs1 = s.use1;
    bus.id_use_rs2 = s.use2;
    bus.imem_ready = s.imem;
    exp_q.push_back(model(s));
  endtask

  // Monitor: compare at the falling edge, mid-cycle
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.pc_we = bus.pc_we; a.pc_src = bus.pc_src; a.rpc = bus.redirect_pc;
      a.stall = bus.if_id_stall; a.iflush = bus.if_id_flush;
      a.eflush = bus.id_ex_flush; a.busy = bus.busy;
      a.rc = bus.redirect_cnt; a.lc = bus.lu_stall_cnt; a.fc = bus.fetch_stall_cnt;
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d t=%0t got we=%b src=%b pc=%h st=%b ff=%b ef=%b busy=%b cnt=%0d/%0d/%0d want we=%b src=%b pc=%h st=%b ff=%b ef=%b busy=%b cnt=%0d/%0d/%0d",
                 n_vec, $time, a.pc_we, a.pc_src, a.rpc, a.stall, a.iflush, a.eflush, a.busy,
                 a.rc, a.lc, a.fc, e.pc_we, e.pc_src, e.rpc, e.stall, e.iflush, e.eflush,
                 e.busy, e.rc, e.lc, e.fc);
      end
    end
  end

  initial begin
    stim_t s, lu_s;
    bus.ex_pcsel = 0; bus.ex_target = '0; bus.ex_memread = 0; bus.ex_rd = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.imem_ready = 1;

    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    apply(idle());

    // Taken branch with fetch ready
    s = idle(); s.pcsel = 1; s.target = 32'h0000_0100; apply(s);
    apply(idle());

    // Redirect under fetch stall, spurious branch to 0x300 while holding
    s = idle(); s.pcsel = 1; s.target = 32'h200; s.imem = 0; apply(s);
    s.target = 32'h300; apply(s); apply(s);
    s.imem = 1; apply(s);
    apply(idle());

    // Load-use, x0 destination, back-to-back
    lu_s = idle(); lu_s.memread = 1; lu_s.ex_rd = 5; lu_s.rs2 = 5; lu_s.use2 = 1;
    apply(lu_s);
    s = lu_s; s.ex_rd = 0; s.rs2 = 0; apply(s);
    apply(lu_s); apply(lu_s);
    s = lu_s; s.imem = 0; apply(s);

    // Branch and load-use together
    s = lu_s; s.pcsel = 1; s.target = 32'h400; apply(s);

    // Reset while holding a redirect
    s = idle(); s.pcsel = 1; s.target = 32'h500; s.imem = 0; apply(s);
    s = idle(); s.imem = 0; apply(s);
    s.rst = 1; apply(s);
    apply(idle()); apply(idle());

    // Sixteen redirects: counter wraps at PW bits
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.pcsel = 1; s.target = $urandom(); apply(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.imem = 0; apply(s);
    end

    // Randomized traffic with narrow register ranges to provoke hazards
    for (int i = 0; i < 800; i++) begin
      s.rst     = ($urandom_range(0, 63) == 0);
      s.pcsel   = ($urandom_range(0, 3) == 0);
      s.target  = $urandom();
      s.memread = $urandom_range(0, 1);
      s.ex_rd   = 5'($urandom_range(0, 3));
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.use1    = $urandom_range(0, 1);
      s.use2    = $urandom_range(0, 1);
      s.imem    = ($urandom_range(0, 9) < 7);
      apply(s);
    end
    apply(idle());

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
